// File: rtl/dma_burst_packer.sv
// Packs FIFO words into header-prefixed bursts for the TLP engine.
// Bursts are capped by maxBurst, the remaining job words and the 4 KB page edge.
module dma_burst_packer (
    input  logic        clockCore,
    input  logic        resetCore,
    input  logic [63:0] fifoDataOut,
    input  logic        fifoEmpty,
    input  logic [3:0]  fifoDepth,
    output logic        fifoPop,
    input  logic        start,
    input  logic        cfgEnable,
    input  logic [31:0] cfgBaseAddr,
    input  logic [15:0] cfgTotalWords,
    input  logic [3:0]  cfgMaxBurst,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] outData,
    output logic        outSop,
    output logic        outEop,
    output logic        busy,
    output logic        done,
    output logic        errAbort,
    output logic [15:0] wordsSent
);

    typedef enum logic [2:0] {sIdle, sWait, sHdr, sData, sDone} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [15:0] remaining;
    logic [3:0]  maxB;
    logic [3:0]  curLen;
    logic [3:0]  beatCnt;
    logic [63:0] hdr;
    logic [3:0]  maxBIn;
    logic [3:0]  len;
    logic [15:0] toBoundary;

    // Burst length: min(remaining, maxB, words left before the 4 KB edge)
    always_comb begin
        maxBIn = cfgMaxBurst;
        if (cfgMaxBurst == 4'd0)
            maxBIn = 4'd1;
        else if (cfgMaxBurst > 4'd8)
            maxBIn = 4'd8;
        toBoundary = 16'd512 - {7'd0, addr[11:3]};
        len = maxB;
        if (remaining < {12'd0, len})
            len = remaining[3:0];
        if (toBoundary < {12'd0, len})
            len = toBoundary[3:0];
    end

    // Payload beats pass the FIFO head straight through; no pop without a handshake
    always_comb begin
        outValid = 1'b0;
        outSop   = 1'b0;
        outEop   = 1'b0;
        outData  = '0;
        fifoPop  = 1'b0;
        case (state)
            sHdr: begin
                outValid = 1'b1;
                outSop   = 1'b1;
                outData  = hdr;
            end
            sData: begin
                outValid = !fifoEmpty;
                outData  = fifoDataOut;
                outEop   = (beatCnt == 4'd1);
                fifoPop  = !fifoEmpty && outReady;
            end
            default: ;
        endcase
    end

    assign busy = (state == sWait) || (state == sHdr) || (state == sData);
    assign done = (state == sDone);

    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            state     <= sIdle;
            addr      <= '0;
            remaining <= '0;
            maxB      <= '0;
            curLen    <= '0;
            beatCnt   <= '0;
            hdr       <= '0;
            errAbort  <= 1'b0;
            wordsSent <= '0;
        end else begin
            case (state)
                sIdle: begin
                    if (start && cfgEnable) begin
                        if (cfgTotalWords == 16'd0) begin
                            state <= sDone;
                        end else begin
                            addr      <= cfgBaseAddr & ~32'h7;
                            remaining <= cfgTotalWords;
                            maxB      <= maxBIn;
                            wordsSent <= '0;
                            errAbort  <= 1'b0;
                            state     <= sWait;
                        end
                    end
                end
                sWait: begin
                    // Abort is only honoured here, so a started burst always completes
                    if (!cfgEnable) begin
                        errAbort <= 1'b1;
                        state    <= sDone;
                    end else if (fifoDepth >= len) begin
                        hdr    <= {addr, 24'd0, 4'd0, len};
                        curLen <= len;
                        state  <= sHdr;
                    end
                end
                sHdr: begin
                    if (outReady) begin
                        beatCnt <= curLen;
                        state   <= sData;
                    end
                end
                sData: begin
                    if (fifoPop) begin
                        beatCnt   <= beatCnt - 4'd1;
                        remaining <= remaining - 16'd1;
                        wordsSent <= wordsSent + 16'd1;
                        if (beatCnt == 4'd1) begin
                            addr  <= addr + {25'd0, curLen, 3'd0};
                            state <= (remaining == 16'd1) ? sDone : sWait;
                        end
                    end
                end
                sDone:   state <= sIdle;
                default: state <= sIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_packer.sv
// Directed bench for dma_burst_packer: a pointer-based FIFO model feeds the DUT,
// a negedge monitor logs accepted beats and checks stall stability.
module tb_dma_burst_packer;

    logic        clockCore;
    logic        resetCore;
    logic [63:0] fifoDataOut;
    logic        fifoEmpty;
    logic [3:0]  fifoDepth;
    logic        fifoPop;
    logic        start;
    logic        cfgEnable;
    logic [31:0] cfgBaseAddr;
    logic [15:0] cfgTotalWords;
    logic [3:0]  cfgMaxBurst;
    logic        outValid;
    logic        outReady;
    logic [63:0] outData;
    logic        outSop;
    logic        outEop;
    logic        busy;
    logic        done;
    logic        errAbort;
    logic [15:0] wordsSent;

    dma_burst_packer dut (
        .clockCore(clockCore), .resetCore(resetCore),
        .fifoDataOut(fifoDataOut), .fifoEmpty(fifoEmpty), .fifoDepth(fifoDepth), .fifoPop(fifoPop),
        .start(start), .cfgEnable(cfgEnable), .cfgBaseAddr(cfgBaseAddr),
        .cfgTotalWords(cfgTotalWords), .cfgMaxBurst(cfgMaxBurst),
        .outValid(outValid), .outReady(outReady), .outData(outData), .outSop(outSop), .outEop(outEop),
        .busy(busy), .done(done), .errAbort(errAbort), .wordsSent(wordsSent)
    );

    initial clockCore = 1'b0;
    always #5 clockCore = ~clockCore;

    int nChk = 0;
    int nErr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FIFO model
    logic [63:0] mem [0:255];
    logic [7:0]  rdPtr = 8'd0;
    logic [7:0]  wrPtr = 8'd0;
    logic [7:0]  occ;
    assign occ         = wrPtr - rdPtr;
    assign fifoEmpty   = (occ == 8'd0);
    assign fifoDepth   = (occ > 8'd8) ? 4'd8 : occ[3:0];
    assign fifoDataOut = mem[rdPtr];
    always @(posedge clockCore) if (fifoPop) rdPtr <= rdPtr + 8'd1;

    task automatic push(input logic [63:0] w);
        mem[wrPtr] = w;
        wrPtr = wrPtr + 8'd1;
    endtask

    task automatic fillWords(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 64'(i));
    endtask

    task automatic fifoClear();
        wrPtr = rdPtr;
    endtask

    // Monitor
    logic [63:0] logData[$];
    logic        logSop[$];
    logic        logEop[$];
    int          logCyc[$];
    int          popCnt = 0;
    int          stallCnt = 0;
    int          cycleCnt = 0;
    logic        prevStall = 1'b0;
    logic [63:0] prevData = '0;
    logic        prevSop = 1'b0;
    logic        prevEop = 1'b0;

    always @(posedge clockCore) cycleCnt <= cycleCnt + 1;

    always @(negedge clockCore) begin
        if (prevStall) begin
            stallCnt++;
            chk("stallData", outData, prevData);
            chk("stallCtl", {outValid, outSop, outEop}, {1'b1, prevSop, prevEop});
        end
        if (outValid && outReady) begin
            logData.push_back(outData);
            logSop.push_back(outSop);
            logEop.push_back(outEop);
            logCyc.push_back(cycleCnt);
        end
        if (fifoPop) begin
            popCnt++;
            chk("popNotEmpty", fifoEmpty, 1'b0);
        end
        prevStall <= outValid && !outReady;
        prevData  <= outData;
        prevSop   <= outSop;
        prevEop   <= outEop;
    end

    // Expected beat list
    logic [63:0] expData[$];
    logic        expSop[$];
    logic        expEop[$];

    task automatic expHdr(input logic [31:0] a, input logic [7:0] len);
        expData.push_back({a, 24'd0, len});
        expSop.push_back(1'b1);
        expEop.push_back(1'b0);
    endtask

    task automatic expWords(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            expData.push_back(base + 64'(i));
            expSop.push_back(1'b0);
            expEop.push_back(i == n - 1);
        end
    endtask

    task automatic clearLog();
        logData.delete(); logSop.delete(); logEop.delete(); logCyc.delete();
        expData.delete(); expSop.delete(); expEop.delete();
        popCnt = 0;
        stallCnt = 0;
    endtask

    task automatic checkLog(input string name);
        chk({name, "Cnt"}, logData.size(), expData.size());
        for (int i = 0; i < logData.size() && i < expData.size(); i++) begin
            chk($sformatf("%sData%0d", name, i), logData[i], expData[i]);
            chk($sformatf("%sSopEop%0d", name, i), {logSop[i], logEop[i]}, {expSop[i], expEop[i]});
        end
    endtask

    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    logic toggleRdy = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clockCore);
            #1;
            if (toggleRdy) outReady = ~outReady;
        end
    endtask

    task automatic startJob(input logic [31:0] base, input logic [15:0] total, input logic [3:0] mb);
        cfgBaseAddr   = base;
        cfgTotalWords = total;
        cfgMaxBurst   = mb;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (done) seen = 1'b1;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        resetCore = 1'b0; start = 1'b0; cfgEnable = 1'b1; outReady = 1'b1;
        cfgBaseAddr = '0; cfgTotalWords = '0; cfgMaxBurst = '0;
        tick(2);
        chk("rstCtl", {outValid, outSop, outEop, fifoPop, busy, done, errAbort}, 7'd0);
        chk("rstData", outData, 64'd0);
        chk("rstWords", wordsSent, 16'd0);
        resetCore = 1'b1;
        tick(1);

        // Basic job with first-header latency
        clearLog();
        fillWords(64'hA000, 8);
        startJob(32'h1000, 16'd6, 4'd4);
        chk("basicWaitCyc", {outValid, busy}, 2'b01);
        tick(1);
        chk("basicHdrCyc", {outValid, outSop}, 2'b11);
        chk("basicHdrData", outData, 64'h00001000_00000004);
        waitDone("basicDone", 100);
        chk("basicWordsSent", wordsSent, 16'd6);
        tick(1);
        chk("basicDoneOnce", {done, busy}, 2'b00);
        expHdr(32'h1000, 8'd4); expWords(64'hA000, 4);
        expHdr(32'h1020, 8'd2); expWords(64'hA004, 2);
        checkLog("basic");
        chk("basicPops", popCnt, 6);
        fifoClear();

        // 4 KB boundary split
        clearLog();
        fillWords(64'hB000, 4);
        startJob(32'h0FF0, 16'd4, 4'd8);
        waitDone("bndDone", 100);
        tick(1);
        expHdr(32'h0FF0, 8'd2); expWords(64'hB000, 2);
        expHdr(32'h1000, 8'd2); expWords(64'hB002, 2);
        checkLog("bnd");
        fifoClear();

        // Backpressure: outReady toggles every cycle
        clearLog();
        fillWords(64'hC000, 6);
        toggleRdy = 1'b1;
        startJob(32'h2000, 16'd6, 4'd8);
        waitDone("bpDone", 200);
        toggleRdy = 1'b0;
        outReady = 1'b1;
        tick(1);
        expHdr(32'h2000, 8'd6); expWords(64'hC000, 6);
        checkLog("bp");
        chk("bpPops", popCnt, 6);
        chk("bpStalled", stallCnt > 0, 1'b1);
        fifoClear();

        // Starvation: depth 2 with len 4 holds in WAIT
        clearLog();
        fillWords(64'hD000, 2);
        startJob(32'h3000, 16'd4, 4'd4);
        begin
            bit sawValid;
            sawValid = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick(1);
                if (outValid) sawValid = 1'b1;
            end
            chk("starveNoHdr", {sawValid, busy}, 2'b01);
        end
        push(64'hD002);
        push(64'hD003);
        waitDone("starveDone", 100);
        tick(1);
        chk("starveGapless", (logCyc.size() == 5) ? logCyc[4] - logCyc[0] : -1, 4);
        expHdr(32'h3000, 8'd4); expWords(64'hD000, 4);
        checkLog("starve");
        fifoClear();

        // Abort: cfgEnable drops during burst 1 of 2
        clearLog();
        fillWords(64'hE000, 8);
        startJob(32'h4000, 16'd8, 4'd4);
        tick(1);
        cfgEnable = 1'b0;
        waitDone("abortDone", 100);
        chk("abortErr", errAbort, 1'b1);
        chk("abortWords", wordsSent, 16'd4);
        tick(1);
        cfgEnable = 1'b1;
        expHdr(32'h4000, 8'd4); expWords(64'hE000, 4);
        checkLog("abort");
        fifoClear();

        // total=0 start: immediate done, no beats
        clearLog();
        startJob(32'h5000, 16'd0, 4'd4);
        chk("zeroDone", {done, busy}, 2'b10);
        tick(2);
        chk("zeroNoBeats", logData.size(), 0);

        // start while busy is ignored
        clearLog();
        startJob(32'h5000, 16'd2, 4'd2);
        chk("busyErrCleared", errAbort, 1'b0);
        tick(2);
        cfgBaseAddr = 32'h6000; cfgTotalWords = 16'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        fillWords(64'hF000, 2);
        waitDone("busyDone", 100);
        chk("busyWords", wordsSent, 16'd2);
        tick(1);
        expHdr(32'h5000, 8'd2); expWords(64'hF000, 2);
        checkLog("busyStart");
        fifoClear();

        // maxBurst=0 behaves as 1
        clearLog();
        fillWords(64'h7700, 2);
        startJob(32'h7000, 16'd2, 4'd0);
        waitDone("mb0Done", 100);
        tick(1);
        expHdr(32'h7000, 8'd1); expWords(64'h7700, 1);
        expHdr(32'h7008, 8'd1); expWords(64'h7701, 1);
        checkLog("mb0");
        fifoClear();

        // Reset mid-burst
        clearLog();
        fillWords(64'h8800, 4);
        startJob(32'h8000, 16'd4, 4'd4);
        tick(2);
        chk("midBurstValid", {outValid, outSop}, 2'b10);
        resetCore = 1'b0;
        tick(1);
        chk("midRstCtl", {outValid, outSop, outEop, fifoPop, busy, done, errAbort}, 7'd0);
        chk("midRstData", outData, 64'd0);
        chk("midRstWords", wordsSent, 16'd0);
        begin
            int eops;
            eops = 0;
            foreach (logEop[i]) if (logEop[i]) eops++;
            chk("midRstNoEop", eops, 0);
        end
        resetCore = 1'b1;
        tick(2);
        chk("midRstIdle", {outValid, busy, done}, 3'b000);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
